// File: rtl/stage_seq.sv
// Multi-cycle core sequencer: walks IFU, IDU, EXU, LSU and WBU one stage at a time,
// skipping LSU for non-memory instructions and stopping on EBREAK or a stage timeout.
module stage_seq #(
   parameter int unsigned CNT_WIDTH  = 32,
   parameter int unsigned TMO_CYCLES = 256
) (
   input  logic                 i_sys_clk,
   input  logic                 i_sys_rst,
   input  logic                 i_seq_start,
   input  logic                 i_ifu_valid,
   output logic                 o_ifu_ready,
   input  logic                 i_idu_valid,
   output logic                 o_idu_ready,
   input  logic                 i_exu_valid,
   output logic                 o_exu_ready,
   input  logic                 i_lsu_valid,
   output logic                 o_lsu_ready,
   input  logic                 i_wbu_valid,
   output logic                 o_wbu_ready,
   input  logic                 i_idu_mem_op,
   input  logic                 i_idu_halt,
   output logic                 o_seq_pc_wr_en,
   output logic [2:0]           o_seq_state,
   output logic                 o_seq_halt,
   output logic                 o_seq_timeout,
   output logic [CNT_WIDTH-1:0] o_seq_inst_cnt,
   output logic [CNT_WIDTH-1:0] o_seq_cycle_cnt
);

   localparam int unsigned TMO_W = 16;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_IF   = 3'd1,
      S_ID   = 3'd2,
      S_EX   = 3'd3,
      S_LS   = 3'd4,
      S_WB   = 3'd5,
      S_HALT = 3'd6
   } state_t;

   state_t               state;
   logic [4:0]           rdy_q;      // {wbu, lsu, exu, idu, ifu}
   logic                 mem_op_q;
   logic                 halt_q;
   logic                 timeout_q;
   logic [TMO_W-1:0]     tmo_cnt;
   logic [CNT_WIDTH-1:0] inst_cnt;
   logic [CNT_WIDTH-1:0] cycle_cnt;
   logic                 in_stage_c;
   logic                 hs_c;

   function automatic logic [4:0] rdy_dec(input state_t s);
      case (s)
         S_IF:    rdy_dec = 5'b00001;
         S_ID:    rdy_dec = 5'b00010;
         S_EX:    rdy_dec = 5'b00100;
         S_LS:    rdy_dec = 5'b01000;
         S_WB:    rdy_dec = 5'b10000;
         default: rdy_dec = 5'b00000;
      endcase
   endfunction

   // Handshake of the stage currently owning the core
   always_comb begin
      in_stage_c = 1'b0;
      hs_c       = 1'b0;
      case (state)
         S_IF: begin in_stage_c = 1'b1; hs_c = i_ifu_valid; end
         S_ID: begin in_stage_c = 1'b1; hs_c = i_idu_valid; end
         S_EX: begin in_stage_c = 1'b1; hs_c = i_exu_valid; end
         S_LS: begin in_stage_c = 1'b1; hs_c = i_lsu_valid; end
         S_WB: begin in_stage_c = 1'b1; hs_c = i_wbu_valid; end
         default: ;
      endcase
   end

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         state     <= S_IDLE;
         rdy_q     <= '0;
         mem_op_q  <= 1'b0;
         halt_q    <= 1'b0;
         timeout_q <= 1'b0;
         tmo_cnt   <= '0;
         inst_cnt  <= '0;
         cycle_cnt <= '0;
      end else begin
         if (in_stage_c)
            cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
         case (state)
            S_IDLE: begin
               if (i_seq_start) begin
                  state <= S_IF;
                  rdy_q <= rdy_dec(S_IF);
               end
            end
            S_HALT: ;
            S_IF, S_ID, S_EX, S_LS, S_WB: begin
               if (hs_c) begin
                  tmo_cnt <= '0;
                  case (state)
                     S_IF: begin
                        state <= S_ID;
                        rdy_q <= rdy_dec(S_ID);
                     end
                     S_ID: begin
                        // EBREAK wins over the memory-op decode
                        if (i_idu_halt) begin
                           state  <= S_HALT;
                           rdy_q  <= '0;
                           halt_q <= 1'b1;
                        end else begin
                           mem_op_q <= i_idu_mem_op;
                           state    <= S_EX;
                           rdy_q    <= rdy_dec(S_EX);
                        end
                     end
                     S_EX: begin
                        if (mem_op_q) begin
                           state <= S_LS;
                           rdy_q <= rdy_dec(S_LS);
                        end else begin
                           state <= S_WB;
                           rdy_q <= rdy_dec(S_WB);
                        end
                     end
                     S_LS: begin
                        state <= S_WB;
                        rdy_q <= rdy_dec(S_WB);
                     end
                     S_WB: begin
                        state    <= S_IF;
                        rdy_q    <= rdy_dec(S_IF);
                        inst_cnt <= inst_cnt + CNT_WIDTH'(1);
                     end
                     default: ;
                  endcase
               end else if (tmo_cnt == TMO_W'(TMO_CYCLES - 1)) begin
                  state     <= S_HALT;
                  rdy_q     <= '0;
                  halt_q    <= 1'b1;
                  timeout_q <= 1'b1;
                  tmo_cnt   <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            // Unused encoding: treat as a fault stop
            default: begin
               state     <= S_HALT;
               rdy_q     <= '0;
               halt_q    <= 1'b1;
               timeout_q <= 1'b1;
               tmo_cnt   <= '0;
            end
         endcase
      end
   end

   assign o_ifu_ready     = rdy_q[0];
   assign o_idu_ready     = rdy_q[1];
   assign o_exu_ready     = rdy_q[2];
   assign o_lsu_ready     = rdy_q[3];
   assign o_wbu_ready     = rdy_q[4];
   assign o_seq_pc_wr_en  = (state == S_WB) & i_wbu_valid;
   assign o_seq_state     = state;
   assign o_seq_halt      = halt_q;
   assign o_seq_timeout   = timeout_q;
   assign o_seq_inst_cnt  = inst_cnt;
   assign o_seq_cycle_cnt = cycle_cnt;

endmodule

// File: tb/tb_stage_seq.sv
// Scoreboard bench for stage_seq: two instances (default and TMO_CYCLES=4/CNT_WIDTH=4)
// share stimulus; expected per-cycle snapshots are queued and checked by a monitor.
module tb_stage_seq;

   logic clk = 1'b0;
   logic rst, start, ifu_v, idu_v, exu_v, lsu_v, wbu_v, mem_op, halt_in;

   logic        a_ifu_r, a_idu_r, a_exu_r, a_lsu_r, a_wbu_r, a_pc, a_halt, a_tmo;
   logic [2:0]  a_st;
   logic [31:0] a_inst, a_cyc;
   logic        b_ifu_r, b_idu_r, b_exu_r, b_lsu_r, b_wbu_r, b_pc, b_halt, b_tmo;
   logic [2:0]  b_st;
   logic [3:0]  b_inst, b_cyc;

   always #5 clk = ~clk;

   stage_seq dut_a (
      .i_sys_clk(clk), .i_sys_rst(rst), .i_seq_start(start),
      .i_ifu_valid(ifu_v), .o_ifu_ready(a_ifu_r),
      .i_idu_valid(idu_v), .o_idu_ready(a_idu_r),
      .i_exu_valid(exu_v), .o_exu_ready(a_exu_r),
      .i_lsu_valid(lsu_v), .o_lsu_ready(a_lsu_r),
      .i_wbu_valid(wbu_v), .o_wbu_ready(a_wbu_r),
      .i_idu_mem_op(mem_op), .i_idu_halt(halt_in),
      .o_seq_pc_wr_en(a_pc), .o_seq_state(a_st), .o_seq_halt(a_halt),
      .o_seq_timeout(a_tmo), .o_seq_inst_cnt(a_inst), .o_seq_cycle_cnt(a_cyc)
   );

   stage_seq #(.CNT_WIDTH(4), .TMO_CYCLES(4)) dut_b (
      .i_sys_clk(clk), .i_sys_rst(rst), .i_seq_start(start),
      .i_ifu_valid(ifu_v), .o_ifu_ready(b_ifu_r),
      .i_idu_valid(idu_v), .o_idu_ready(b_idu_r),
      .i_exu_valid(exu_v), .o_exu_ready(b_exu_r),
      .i_lsu_valid(lsu_v), .o_lsu_ready(b_lsu_r),
      .i_wbu_valid(wbu_v), .o_wbu_ready(b_wbu_r),
      .i_idu_mem_op(mem_op), .i_idu_halt(halt_in),
      .o_seq_pc_wr_en(b_pc), .o_seq_state(b_st), .o_seq_halt(b_halt),
      .o_seq_timeout(b_tmo), .o_seq_inst_cnt(b_inst), .o_seq_cycle_cnt(b_cyc)
   );

   typedef struct {
      string       name;
      bit          use_b;
      logic [2:0]  st;
      logic        pc;
      logic        halt;
      logic        tmo;
      logic [31:0] inst;
      logic [31:0] cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Ready one-hot {wbu, lsu, exu, idu, ifu} required for a given state
   function automatic logic [4:0] want_rdy(input logic [2:0] st);
      case (st)
         3'd1:    want_rdy = 5'b00001;
         3'd2:    want_rdy = 5'b00010;
         3'd3:    want_rdy = 5'b00100;
         3'd4:    want_rdy = 5'b01000;
         3'd5:    want_rdy = 5'b10000;
         default: want_rdy = 5'b00000;
      endcase
   endfunction

   task automatic expect_snap(input string name, input bit use_b, input logic [2:0] st,
                              input logic pc, input logic halt, input logic tmo,
                              input int inst, input int cyc);
      exp_t e;
      e.name = name; e.use_b = use_b; e.st = st; e.pc = pc;
      e.halt = halt; e.tmo = tmo; e.inst = 32'(inst); e.cyc = 32'(cyc);
      q.push_back(e);
   endtask

   // Monitor: compares every queued snapshot at the falling edge
   initial begin
      exp_t        e;
      logic [2:0]  g_st;
      logic [4:0]  g_rdy, w_rdy;
      logic        g_pc, g_halt, g_tmo;
      logic [31:0] g_inst, g_cyc;
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            e = q.pop_front();
            if (e.use_b) begin
               g_st = b_st; g_rdy = {b_wbu_r, b_lsu_r, b_exu_r, b_idu_r, b_ifu_r};
               g_pc = b_pc; g_halt = b_halt; g_tmo = b_tmo;
               g_inst = 32'(b_inst); g_cyc = 32'(b_cyc);
            end else begin
               g_st = a_st; g_rdy = {a_wbu_r, a_lsu_r, a_exu_r, a_idu_r, a_ifu_r};
               g_pc = a_pc; g_halt = a_halt; g_tmo = a_tmo;
               g_inst = a_inst; g_cyc = a_cyc;
            end
            w_rdy = want_rdy(e.st);
            checks++;
            if ({g_st, g_rdy, g_pc, g_halt, g_tmo, g_inst, g_cyc} !==
                {e.st, w_rdy, e.pc, e.halt, e.tmo, e.inst, e.cyc}) begin
               errors++;
               $display("FAIL %s: got st=%0d rdy=%b pc=%b halt=%b tmo=%b inst=%0d cyc=%0d; expected st=%0d rdy=%b pc=%b halt=%b tmo=%b inst=%0d cyc=%0d",
                        e.name, g_st, g_rdy, g_pc, g_halt, g_tmo, g_inst, g_cyc,
                        e.st, w_rdy, e.pc, e.halt, e.tmo, e.inst, e.cyc);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_valids(input logic v);
      ifu_v = v; idu_v = v; exu_v = v; lsu_v = v; wbu_v = v;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; mem_op = 1'b0; halt_in = 1'b0;
      set_valids(1'b0);
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mem_op = 1'b0; halt_in = 1'b0;
      set_valids(1'b0);

      // Non-memory instruction with zero-wait stages
      do_reset();
      expect_snap("reset_a", 0, 3'd0, 0, 0, 0, 0, 0);
      expect_snap("reset_b", 1, 3'd0, 0, 0, 0, 0, 0);
      start = 1'b1; set_valids(1'b1);
      step(); expect_snap("nm_c1_if", 0, 3'd1, 0, 0, 0, 0, 0);
      step(); expect_snap("nm_c2_id", 0, 3'd2, 0, 0, 0, 0, 1);
      step(); expect_snap("nm_c3_ex", 0, 3'd3, 0, 0, 0, 0, 2);
      step(); expect_snap("nm_c4_wb", 0, 3'd5, 1, 0, 0, 0, 3);
      step(); expect_snap("nm_c5_if", 0, 3'd1, 0, 0, 0, 1, 4);

      // Memory instruction visits LS
      do_reset();
      mem_op = 1'b1; start = 1'b1; set_valids(1'b1);
      step(); expect_snap("m_c1_if", 0, 3'd1, 0, 0, 0, 0, 0);
      step(); expect_snap("m_c2_id", 0, 3'd2, 0, 0, 0, 0, 1);
      step(); expect_snap("m_c3_ex", 0, 3'd3, 0, 0, 0, 0, 2);
      step(); expect_snap("m_c4_ls", 0, 3'd4, 0, 0, 0, 0, 3);
      step(); expect_snap("m_c5_wb", 0, 3'd5, 1, 0, 0, 0, 4);
      step(); expect_snap("m_c6_if", 0, 3'd1, 0, 0, 0, 1, 5);

      // EXU stall of 3 cycles; also handshake on the timeout cycle for TMO_CYCLES=4
      do_reset();
      start = 1'b1; set_valids(1'b1); exu_v = 1'b0;
      step(); step();
      step(); expect_snap("st_ex1", 0, 3'd3, 0, 0, 0, 0, 2);
      step(); expect_snap("st_ex2", 0, 3'd3, 0, 0, 0, 0, 3);
      step(); expect_snap("st_ex3", 0, 3'd3, 0, 0, 0, 0, 4);
      step(); exu_v = 1'b1;
      expect_snap("st_ex4", 0, 3'd3, 0, 0, 0, 0, 5);
      step(); expect_snap("st_wb_a", 0, 3'd5, 1, 0, 0, 0, 6);
      expect_snap("st_wb_b", 1, 3'd5, 1, 0, 0, 0, 6);
      step(); expect_snap("st_if_a", 0, 3'd1, 0, 0, 0, 1, 7);

      // EBREAK together with mem_op
      do_reset();
      mem_op = 1'b1; halt_in = 1'b1; start = 1'b1; set_valids(1'b1);
      step(); step(); expect_snap("h_id", 0, 3'd2, 0, 0, 0, 0, 1);
      step(); expect_snap("h_halt", 0, 3'd6, 0, 1, 0, 0, 2);
      start = 1'b0; set_valids(1'b0);
      step(); expect_snap("h_stay1", 0, 3'd6, 0, 1, 0, 0, 2);
      start = 1'b1; set_valids(1'b1);
      step(); expect_snap("h_stay2", 0, 3'd6, 0, 1, 0, 0, 2);
      step(); expect_snap("h_stay3", 1, 3'd6, 0, 1, 0, 0, 2);

      // IFU timeout with TMO_CYCLES=4
      do_reset();
      start = 1'b1; set_valids(1'b1); ifu_v = 1'b0;
      step(); step(); step();
      step(); expect_snap("to_if4_b", 1, 3'd1, 0, 0, 0, 0, 3);
      step(); expect_snap("to_halt_b", 1, 3'd6, 0, 1, 1, 0, 4);
      expect_snap("to_still_if_a", 0, 3'd1, 0, 0, 0, 0, 4);

      // Valid rising on the 4th IF cycle beats the timeout
      do_reset();
      start = 1'b1; set_valids(1'b1); ifu_v = 1'b0;
      step(); step(); step();
      step(); ifu_v = 1'b1;
      step(); expect_snap("to_win_b", 1, 3'd2, 0, 0, 0, 0, 4);

      // Reset mid-instruction in LS
      do_reset();
      mem_op = 1'b1; start = 1'b1; set_valids(1'b1);
      step(); step(); step();
      step(); expect_snap("r_ls", 0, 3'd4, 0, 0, 0, 0, 3);
      rst = 1'b1;
      step(); rst = 1'b0; start = 1'b0;
      expect_snap("r_idle_a", 0, 3'd0, 0, 0, 0, 0, 0);
      expect_snap("r_idle_b", 1, 3'd0, 0, 0, 0, 0, 0);

      // 16 retirements: 4-bit counters wrap
      do_reset();
      start = 1'b1; set_valids(1'b1);
      for (int c = 1; c <= 65; c++) begin
         step();
         if (c == 61) begin
            expect_snap("w_c61_a", 0, 3'd1, 0, 0, 0, 15, 60);
            expect_snap("w_c61_b", 1, 3'd1, 0, 0, 0, 15, 12);
         end
         if (c == 64) expect_snap("w_c64_b", 1, 3'd5, 1, 0, 0, 15, 15);
         if (c == 65) begin
            expect_snap("w_c65_a", 0, 3'd1, 0, 0, 0, 16, 64);
            expect_snap("w_c65_b", 1, 3'd1, 0, 0, 0, 0, 0);
         end
      end

      step(); step();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending snapshots, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
